// File: rtl/spi_slave_core_pkg.sv
// Purpose: shared types and constants for the SPI slave endpoint.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_slave_core_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slv_state_e;

    // Flops in each pin synchronizer, not counting the edge-detect delay flop.
    localparam int SPI_SYNC_STAGES = 2;

    // Width of the bit counter for a frame of dw bits (counts 0..dw-1).
    function automatic int spi_cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/spi_slave_core_if.sv
// Purpose: local-side tx/rx word handshake and status pulses of the SPI slave.
// Latency: n/a (wiring only).
// Backpressure: tx side is valid/ready; rx side holds rx_data until rx_ack.
// Ports: tx_data/tx_valid/tx_ready push words to send; rx_data/rx_valid/rx_ack
//        hand over received words; rx_overrun/tx_underrun/frame_abort are
//        one-cycle status pulses; busy mirrors the ACTIVE state.
interface spi_slave_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ack;
    logic                  rx_overrun;
    logic                  tx_underrun;
    logic                  frame_abort;
    logic                  busy;

    // Core side.
    modport slave (
        input  tx_data, tx_valid, rx_ack,
        output tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, frame_abort, busy
    );

    // Local logic side.
    modport master (
        output tx_data, tx_valid, rx_ack,
        input  tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, frame_abort, busy
    );
endinterface

// File: rtl/spi_slave_core_sync.sv
// Purpose: synchronize one asynchronous pin into pclk and flag its edges.
// Latency: pin change visible on lvl/rise/fall after SPI_SYNC_STAGES pclk edges.
// Backpressure: none; free-running.
// Ports: pclk/preset_n clock and sync reset; pin raw input; lvl synchronized
//        level; rise/fall one-cycle edge strobes.
module spi_slave_sync
    import spi_slave_core_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic pin,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [SPI_SYNC_STAGES-1:0] sync_q;
    logic                       dly_q;

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            sync_q <= {SPI_SYNC_STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SPI_SYNC_STAGES-2:0], pin};
            dly_q  <= sync_q[SPI_SYNC_STAGES-1];
        end
    end

    assign lvl  = sync_q[SPI_SYNC_STAGES-1];
    assign rise =  lvl & ~dly_q;
    assign fall = ~lvl &  dly_q;

endmodule

// File: rtl/spi_slave_core.sv
// Purpose: full-duplex SPI slave (modes 0-3) oversampling sclk/ss_n/mosi in pclk.
// Latency: 3 pclk from a pin edge to its action; rx word valid 3 pclk after last sample edge.
// Backpressure: one-entry tx buffer (tx_ready = empty); rx word held until rx_ack, overwritten on overrun.
// Ports: pclk/preset_n clock and sync reset; sclk_in/ss_n/mosi async SPI pins;
//        miso/miso_oe SPI output; cpol/cpha mode select; bus carries the
//        local tx/rx handshake and status pulses.
module spi_slave_core
    import spi_slave_core_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] UNDERRUN_FILL = '0
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic sclk_in,
    input  logic ss_n,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    input  logic cpol,
    input  logic cpha,
    spi_slave_core_if.slave bus
);

    localparam int             CNT_W    = spi_cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic ss_lvl_unused, ss_rise, ss_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_slave_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .pclk(pclk), .preset_n(preset_n), .pin(sclk_in),
        .lvl(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_slave_sync #(.RST_VAL(1'b1)) u_sync_ss (
        .pclk(pclk), .preset_n(preset_n), .pin(ss_n),
        .lvl(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall)
    );
    spi_slave_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .pclk(pclk), .preset_n(preset_n), .pin(mosi),
        .lvl(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_slv_state_e        state_q, state_d;
    logic                  cpol_q, cpha_q, skip_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic                  buf_full_q;
    logic [DATA_WIDTH-1:0] buf_dat_q, tx_shift_q, rx_data_q;
    logic [DATA_WIDTH-2:0] rx_shift_q;
    logic                  rx_valid_q, rx_overrun_q, tx_underrun_q, frame_abort_q;

    // Leading edge leaves the idle level; cpha picks which edge samples.
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge  : trail_edge;

    logic load_evt, sample_evt, complete_evt, shift_evt, abort_evt, busy_c;
    logic tx_wr;
    logic [DATA_WIDTH-1:0] rx_word;

    assign tx_wr   = bus.tx_valid && !buf_full_q;
    assign rx_word = {rx_shift_q, mosi_lvl};

    always_ff @(posedge pclk) begin
        if (!preset_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) begin
            if (ss_fall) state_d = ACTIVE;
        end else begin
            if (ss_rise) state_d = IDLE;
        end
    end

    // Deselect wins over any sclk edge seen in the same cycle.
    always_comb begin
        load_evt     = 1'b0;
        sample_evt   = 1'b0;
        complete_evt = 1'b0;
        shift_evt    = 1'b0;
        abort_evt    = 1'b0;
        busy_c       = (state_q == ACTIVE);
        if (state_q == IDLE) begin
            load_evt = ss_fall;
        end else if (ss_rise) begin
            abort_evt = (bit_cnt_q != '0);
        end else begin
            sample_evt   = sample_edge;
            shift_evt    = shift_edge;
            complete_evt = sample_edge && (bit_cnt_q == LAST_BIT);
            load_evt     = complete_evt;
        end
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            skip_q        <= 1'b0;
            bit_cnt_q     <= '0;
            buf_full_q    <= 1'b0;
            buf_dat_q     <= '0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= load_evt && !buf_full_q;
            frame_abort_q <= abort_evt;

            if (state_q == IDLE && ss_fall) begin
                cpol_q     <= cpol;
                cpha_q     <= cpha;
                skip_q     <= cpha;
                bit_cnt_q  <= '0;
                rx_shift_q <= '0;
            end

            // A write colliding with an empty-buffer load still lands in the buffer.
            if (tx_wr) buf_dat_q <= bus.tx_data;
            if (load_evt) begin
                tx_shift_q <= buf_full_q ? buf_dat_q : UNDERRUN_FILL;
                buf_full_q <= tx_wr;
            end else if (tx_wr) begin
                buf_full_q <= 1'b1;
            end

            // The edge right after a load is swallowed so the new MSB stays on miso.
            if (shift_evt) begin
                if (skip_q) skip_q     <= 1'b0;
                else        tx_shift_q <= tx_shift_q << 1;
            end

            if (sample_evt) begin
                rx_shift_q <= rx_word[DATA_WIDTH-2:0];
                bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
            end

            if (complete_evt) begin
                bit_cnt_q    <= '0;
                skip_q       <= 1'b1;
                rx_data_q    <= rx_word;
                rx_valid_q   <= 1'b1;
                rx_overrun_q <= rx_valid_q && !bus.rx_ack;
            end else if (bus.rx_ack) begin
                rx_valid_q <= 1'b0;
            end

            if (abort_evt) begin
                bit_cnt_q  <= '0;
                rx_shift_q <= '0;
            end
        end
    end

    assign miso            = tx_shift_q[DATA_WIDTH-1];
    assign miso_oe         = busy_c;
    assign bus.busy        = busy_c;
    assign bus.tx_ready    = !buf_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_overrun  = rx_overrun_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Purpose: directed self-checking bench for spi_slave_core acting as an SPI master.
// Latency: sclk half period of 8 pclk, well inside the pclk/6 limit.
// Backpressure: bench drives tx words and rx_ack directly through the interface.
module tb_spi_slave_core;
    import spi_slave_core_pkg::*;

    logic pclk = 1'b0;
    logic preset_n, sclk_in, ss_n, mosi, cpol, cpha;
    logic miso, miso_oe;

    int tests_run = 0;
    int tests_failed = 0;
    int ovr_cnt = 0, und_cnt = 0, abt_cnt = 0;

    spi_slave_core_if #(.DATA_WIDTH(8)) bus ();

    spi_slave_core #(.DATA_WIDTH(8), .UNDERRUN_FILL(8'h00)) dut (
        .pclk(pclk), .preset_n(preset_n), .sclk_in(sclk_in), .ss_n(ss_n),
        .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha),
        .bus(bus)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (bus.rx_overrun)  ovr_cnt++;
        if (bus.tx_underrun) und_cnt++;
        if (bus.frame_abort) abt_cnt++;
    end

    task automatic half();
        repeat (8) @(negedge pclk);
    endtask

    task automatic tx_push(input logic [7:0] d);
        @(negedge pclk);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge pclk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic ack();
        @(negedge pclk);
        bus.rx_ack = 1'b1;
        @(negedge pclk);
        bus.rx_ack = 1'b0;
    endtask

    task automatic set_mode(input logic p, input logic h);
        cpol    = p;
        cpha    = h;
        sclk_in = p;
        repeat (4) @(negedge pclk);
    endtask

    task automatic select();
        @(negedge pclk);
        ss_n = 1'b0;
        repeat (8) @(negedge pclk);
    endtask

    task automatic deselect();
        half();
        ss_n = 1'b1;
        repeat (5) @(negedge pclk);
    endtask

    // Master side: drives nbits of mo MSB first and captures miso into mi.
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            if (!cpha) begin
                mosi = mo[7-k];
                half();
                sclk_in = ~sclk_in;
                mi[7-k] = miso;
                half();
                sclk_in = ~sclk_in;
            end else begin
                half();
                sclk_in = ~sclk_in;
                mosi = mo[7-k];
                half();
                sclk_in = ~sclk_in;
                mi[7-k] = miso;
            end
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if (bus.tx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_ready got %b exp 1", bus.tx_ready); end
        tests_run++;
        if ({bus.rx_valid, bus.busy, miso, miso_oe} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_ctrl got %b exp 0000", {bus.rx_valid, bus.busy, miso, miso_oe});
        end
        tests_run++;
        if (bus.rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data got %h exp 00", bus.rx_data); end
    endtask

    task automatic test_mode0_basic();
        logic [7:0] mi;
        int u0;
        set_mode(1'b0, 1'b0);
        tx_push(8'h3C);
        tests_run++;
        if (bus.tx_ready !== 1'b0) begin tests_failed++; $display("FAIL t1_preload_ready got %b exp 0", bus.tx_ready); end
        u0 = und_cnt;
        @(negedge pclk);
        ss_n = 1'b0;
        repeat (2) @(negedge pclk);
        tests_run++;
        if (bus.tx_ready !== 1'b0) begin tests_failed++; $display("FAIL t1_ready_at_2 got %b exp 0", bus.tx_ready); end
        @(negedge pclk);
        tests_run++;
        if (bus.tx_ready !== 1'b1 || bus.busy !== 1'b1 || miso_oe !== 1'b1) begin
            tests_failed++; $display("FAIL t1_load_at_3 got ready=%b busy=%b oe=%b exp 1 1 1", bus.tx_ready, bus.busy, miso_oe);
        end
        repeat (5) @(negedge pclk);
        xfer(8'hA5, 8, mi);
        repeat (5) @(negedge pclk);
        tests_run++;
        if (bus.rx_data !== 8'hA5 || bus.rx_valid !== 1'b1) begin
            tests_failed++; $display("FAIL t1_rx got %h/%b exp a5/1", bus.rx_data, bus.rx_valid);
        end
        tests_run++;
        if (mi !== 8'h3C) begin tests_failed++; $display("FAIL t1_miso got %h exp 3c", mi); end
        tests_run++;
        if (und_cnt - u0 !== 1) begin tests_failed++; $display("FAIL t1_end_underrun got %0d exp 1", und_cnt - u0); end
        deselect();
        tests_run++;
        if (bus.busy !== 1'b0 || miso_oe !== 1'b0) begin
            tests_failed++; $display("FAIL t1_idle got busy=%b oe=%b exp 0 0", bus.busy, miso_oe);
        end
        ack();
        tests_run++;
        if (bus.rx_valid !== 1'b0) begin tests_failed++; $display("FAIL t1_ack got %b exp 0", bus.rx_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi1, mi2;
        int o0, u0, a0;
        set_mode(1'b1, 1'b1);
        tx_push(8'h56);
        o0 = ovr_cnt; u0 = und_cnt; a0 = abt_cnt;
        @(negedge pclk);
        ss_n = 1'b0;
        repeat (4) @(negedge pclk);
        tx_push(8'h78);
        tests_run++;
        if (bus.tx_ready !== 1'b0) begin tests_failed++; $display("FAIL t2_buf_full got %b exp 0", bus.tx_ready); end
        repeat (4) @(negedge pclk);
        xfer(8'h12, 8, mi1);
        repeat (5) @(negedge pclk);
        tests_run++;
        if (bus.rx_data !== 8'h12 || bus.rx_valid !== 1'b1) begin
            tests_failed++; $display("FAIL t2_rx1 got %h/%b exp 12/1", bus.rx_data, bus.rx_valid);
        end
        ack();
        tx_push(8'h9A);
        xfer(8'h34, 8, mi2);
        repeat (5) @(negedge pclk);
        tests_run++;
        if (bus.rx_data !== 8'h34 || bus.rx_valid !== 1'b1) begin
            tests_failed++; $display("FAIL t2_rx2 got %h/%b exp 34/1", bus.rx_data, bus.rx_valid);
        end
        tests_run++;
        if (mi1 !== 8'h56 || mi2 !== 8'h78) begin
            tests_failed++; $display("FAIL t2_miso got %h %h exp 56 78", mi1, mi2);
        end
        ack();
        deselect();
        tests_run++;
        if (ovr_cnt != o0 || und_cnt != u0 || abt_cnt != a0) begin
            tests_failed++; $display("FAIL t2_pulses got ovr=%0d und=%0d abt=%0d exp 0 0 0", ovr_cnt - o0, und_cnt - u0, abt_cnt - a0);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] mi;
        int u0;
        set_mode(1'b0, 1'b1);
        u0 = und_cnt;
        select();
        tests_run++;
        if (und_cnt - u0 !== 1) begin tests_failed++; $display("FAIL t3_underrun got %0d exp 1", und_cnt - u0); end
        xfer(8'h69, 8, mi);
        repeat (5) @(negedge pclk);
        tests_run++;
        if (mi !== 8'h00) begin tests_failed++; $display("FAIL t3_fill got %h exp 00", mi); end
        tests_run++;
        if (bus.rx_data !== 8'h69 || bus.rx_valid !== 1'b1) begin
            tests_failed++; $display("FAIL t3_rx got %h/%b exp 69/1", bus.rx_data, bus.rx_valid);
        end
        tests_run++;
        if (und_cnt - u0 !== 2) begin tests_failed++; $display("FAIL t3_end_underrun got %0d exp 2", und_cnt - u0); end
        ack();
        deselect();
    endtask

    task automatic test_overrun();
        logic [7:0] mi;
        int o0;
        set_mode(1'b0, 1'b0);
        o0 = ovr_cnt;
        select();
        xfer(8'h81, 8, mi);
        repeat (5) @(negedge pclk);
        tests_run++;
        if (bus.rx_data !== 8'h81 || ovr_cnt != o0) begin
            tests_failed++; $display("FAIL t4_first got %h ovr=%0d exp 81 0", bus.rx_data, ovr_cnt - o0);
        end
        xfer(8'h7E, 8, mi);
        repeat (5) @(negedge pclk);
        tests_run++;
        if (ovr_cnt - o0 !== 1) begin tests_failed++; $display("FAIL t4_overrun got %0d exp 1", ovr_cnt - o0); end
        tests_run++;
        if (bus.rx_data !== 8'h7E || bus.rx_valid !== 1'b1) begin
            tests_failed++; $display("FAIL t4_rx got %h/%b exp 7e/1", bus.rx_data, bus.rx_valid);
        end
        deselect();
    endtask

    task automatic test_abort();
        logic [7:0] mi;
        int a0;
        a0 = abt_cnt;
        select();
        xfer(8'hFF, 5, mi);
        deselect();
        tests_run++;
        if (abt_cnt - a0 !== 1) begin tests_failed++; $display("FAIL t5_abort got %0d exp 1", abt_cnt - a0); end
        tests_run++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h7E) begin
            tests_failed++; $display("FAIL t5_rx_kept got %h/%b exp 7e/1", bus.rx_data, bus.rx_valid);
        end
        tests_run++;
        if (bus.busy !== 1'b0 || miso_oe !== 1'b0) begin
            tests_failed++; $display("FAIL t5_idle got busy=%b oe=%b exp 0 0", bus.busy, miso_oe);
        end
        ack();
        select();
        xfer(8'hC3, 8, mi);
        repeat (5) @(negedge pclk);
        tests_run++;
        if (bus.rx_data !== 8'hC3 || bus.rx_valid !== 1'b1) begin
            tests_failed++; $display("FAIL t5_next_rx got %h/%b exp c3/1", bus.rx_data, bus.rx_valid);
        end
        deselect();
        tests_run++;
        if (abt_cnt - a0 !== 1) begin tests_failed++; $display("FAIL t5_clean_deselect got %0d exp 1", abt_cnt - a0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] mi;
        tx_push(8'hF0);
        select();
        xfer(8'hFF, 3, mi);
        tests_run++;
        if (miso !== 1'b1 || bus.busy !== 1'b1) begin
            tests_failed++; $display("FAIL t6_pre got miso=%b busy=%b exp 1 1", miso, bus.busy);
        end
        @(negedge pclk);
        preset_n = 1'b0;
        @(negedge pclk);
        tests_run++;
        if ({bus.busy, miso, miso_oe, bus.rx_valid, bus.rx_overrun, bus.tx_underrun, bus.frame_abort} !== 7'b0) begin
            tests_failed++; $display("FAIL t6_reset_ctrl got %b exp 0000000",
                {bus.busy, miso, miso_oe, bus.rx_valid, bus.rx_overrun, bus.tx_underrun, bus.frame_abort});
        end
        tests_run++;
        if (bus.tx_ready !== 1'b1 || bus.rx_data !== 8'h00) begin
            tests_failed++; $display("FAIL t6_reset_data got ready=%b rx=%h exp 1 00", bus.tx_ready, bus.rx_data);
        end
        ss_n    = 1'b1;
        sclk_in = 1'b0;
        repeat (4) @(negedge pclk);
        preset_n = 1'b1;
        repeat (4) @(negedge pclk);
        tx_push(8'hC5);
        select();
        xfer(8'h5A, 8, mi);
        repeat (5) @(negedge pclk);
        tests_run++;
        if (bus.rx_data !== 8'h5A || bus.rx_valid !== 1'b1) begin
            tests_failed++; $display("FAIL t6_rx got %h/%b exp 5a/1", bus.rx_data, bus.rx_valid);
        end
        tests_run++;
        if (mi !== 8'hC5) begin tests_failed++; $display("FAIL t6_miso got %h exp c5", mi); end
        deselect();
    endtask

    initial begin
        preset_n     = 1'b0;
        sclk_in      = 1'b0;
        ss_n         = 1'b1;
        mosi         = 1'b0;
        cpol         = 1'b0;
        cpha         = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        bus.rx_ack   = 1'b0;
        repeat (5) @(negedge pclk);
        test_reset();
        preset_n = 1'b1;
        repeat (4) @(negedge pclk);
        test_mode0_basic();
        test_back_to_back();
        test_underrun();
        test_overrun();
        test_abort();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
